// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: segment bit order and the hex glyph table.
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high {g,f,e,d,c,b,a}; lowercase b and d keep them distinct from 8 and 0.
    localparam logic [SEG_W-1:0] GLYPH_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph lookup, active-high segment form.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0]       nib_i,
    output logic [SEG_W-1:0] glyph_o
);

    always_comb begin
        glyph_o = GLYPH_TAB[nib_i];
    end

endmodule

// File: rtl/m_7seg_scan_driver.sv
// Multiplexed seven-segment scan driver: prescaled digit scan with per-slot dead time,
// frame-aligned double-buffered display data and leading-zero blanking.
module m_7seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD_CYC   = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [SEG_W-1:0]        segment,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD     = PW'(DEAD_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_hex_q, pend_hex_d, disp_hex_q, disp_hex_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic                    pend_blz_q, pend_blz_d, disp_blz_q, disp_blz_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    fs_q, fs_d;

    logic                    pre_wrap, frame_wrap, slot_on;
    logic [3:0]              cur_nib;
    logic [SEG_W-1:0]        cur_glyph;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   anode_sel;

    seg7_glyph u_glyph (
        .nib_i   (cur_nib),
        .glyph_o (cur_glyph)
    );

    always_comb begin
        pre_wrap   = (pre_q == PRE_LAST);
        frame_wrap = pre_wrap && (idx_q == IDX_LAST);
        pre_d      = pre_wrap ? '0 : pre_q + 1'b1;
        idx_d      = idx_q;
        if (pre_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        pend_hex_d = load ? hex_in   : pend_hex_q;
        pend_dp_d  = load ? dp_in    : pend_dp_q;
        pend_blz_d = load ? blank_lz : pend_blz_q;

        // Display only swaps at the frame edge, so a load in that same cycle waits a frame.
        disp_hex_d = frame_wrap ? pend_hex_q : disp_hex_q;
        disp_dp_d  = frame_wrap ? pend_dp_q  : disp_dp_q;
        disp_blz_d = frame_wrap ? pend_blz_q : disp_blz_q;
    end

    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (disp_hex_q[4*i +: 4] == 4'h0);
            lz_blank[i] = disp_blz_q && zero_run && !disp_dp_q[i];
        end
    end

    always_comb begin
        cur_nib   = disp_hex_q[{idx_q, 2'b00} +: 4];
        slot_on   = (pre_q >= DEAD);
        anode_sel = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;

        seg_d   = {SEG_W{POL}} ^ ((slot_on && !lz_blank[idx_q]) ? cur_glyph : '0);
        dp_d    = POL ^ (slot_on && disp_dp_q[idx_q]);
        anode_d = {NUM_DIGITS{POL}} ^ (slot_on ? anode_sel : '0);
        fs_d    = (pre_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            idx_q      <= '0;
            pend_hex_q <= '0;
            pend_dp_q  <= '0;
            pend_blz_q <= 1'b0;
            disp_hex_q <= '0;
            disp_dp_q  <= '0;
            disp_blz_q <= 1'b0;
            seg_q      <= {SEG_W{POL}};
            dp_q       <= POL;
            anode_q    <= {NUM_DIGITS{POL}};
            fs_q       <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            pend_hex_q <= pend_hex_d;
            pend_dp_q  <= pend_dp_d;
            pend_blz_q <= pend_blz_d;
            disp_hex_q <= disp_hex_d;
            disp_dp_q  <= disp_dp_d;
            disp_blz_q <= disp_blz_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            anode_q    <= anode_d;
            fs_q       <= fs_d;
        end
    end

    assign segment     = seg_q;
    assign dp          = dp_q;
    assign anode       = anode_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_m_7seg_scan_driver.sv
// Directed bench for m_7seg_scan_driver with a 4-digit, 4-cycle-slot, active-low setup.
module tb_m_7seg_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  anode;
    logic        frame_start;

    int vectors;
    int miscompares;

    logic [3:0] cap_an [16];
    logic [6:0] cap_sg [16];
    logic       cap_dp [16];
    logic       cap_fs [16];
    bit         cap_to;

    m_7seg_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .DEAD_CYC   (1),
        .ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hex_in      (hex_in),
        .dp_in       (dp_in),
        .load        (load),
        .blank_lz    (blank_lz),
        .segment     (segment),
        .dp          (dp),
        .anode       (anode),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic b);
        repeat (4) @(negedge clk);
        hex_in = h; dp_in = d; blank_lz = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Waits (bounded) for frame_start, then records one 16-cycle frame.
    task automatic capture_frame();
        int t;
        cap_to = 1'b1;
        t = 0;
        while (cap_to && t < 40) begin
            @(negedge clk);
            if (frame_start === 1'b1) cap_to = 1'b0;
            t++;
        end
        if (!cap_to) begin
            for (int i = 0; i < 16; i++) begin
                if (i > 0) @(negedge clk);
                cap_an[i] = anode; cap_sg[i] = segment; cap_dp[i] = dp; cap_fs[i] = frame_start;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; hex_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (anode !== 4'hF) begin miscompares++; $display("FAIL rst_anode got %h want f", anode); end
        vectors++; if (segment !== 7'h7F) begin miscompares++; $display("FAIL rst_seg got %h want 7f", segment); end
        vectors++; if (dp !== 1'b1) begin miscompares++; $display("FAIL rst_dp got %b want 1", dp); end
        vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL rst_fs got %b want 0", frame_start); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL rel_fs got %b want 1", frame_start); end
        vectors++; if (anode !== 4'hF) begin miscompares++; $display("FAIL rel_dead got %h want f", anode); end
        @(negedge clk);
        vectors++; if (anode !== 4'b1110) begin miscompares++; $display("FAIL rel_anode got %b want 1110", anode); end
        vectors++; if (segment !== ~7'h3F) begin miscompares++; $display("FAIL rel_seg got %h want %h", segment, ~7'h3F); end
        vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL rel_fs_drop got %b want 0", frame_start); end
    endtask

    task automatic test_basic();
        logic [6:0] es [4];
        logic [3:0] ea;
        logic [6:0] eg;
        es = '{~7'h66, ~7'h4F, ~7'h5B, ~7'h06};
        do_load(16'h1234, 4'b0000, 1'b0);
        capture_frame();
        vectors++; if (cap_to) begin miscompares++; $display("FAIL basic_timeout got none want frame_start"); end
        for (int k = 0; k < 16; k++) begin
            ea = (k % 4 != 0) ? ~(4'b0001 << (k / 4)) : 4'hF;
            eg = (k % 4 != 0) ? es[k / 4] : 7'h7F;
            vectors++; if (cap_an[k] !== ea) begin miscompares++; $display("FAIL basic_anode[%0d] got %b want %b", k, cap_an[k], ea); end
            vectors++; if (cap_sg[k] !== eg) begin miscompares++; $display("FAIL basic_seg[%0d] got %h want %h", k, cap_sg[k], eg); end
            vectors++; if (cap_dp[k] !== 1'b1) begin miscompares++; $display("FAIL basic_dp[%0d] got %b want 1", k, cap_dp[k]); end
            vectors++; if (cap_fs[k] !== (k == 0)) begin miscompares++; $display("FAIL basic_fs[%0d] got %b want %b", k, cap_fs[k], k == 0); end
        end
    endtask

    task automatic test_lz();
        logic [6:0] es [4];
        logic [6:0] eg;
        es = '{~7'h5B, ~7'h66, 7'h7F, 7'h7F};
        do_load(16'h0042, 4'b0000, 1'b1);
        capture_frame();
        vectors++; if (cap_to) begin miscompares++; $display("FAIL lz_timeout got none want frame_start"); end
        for (int k = 0; k < 16; k++) begin
            eg = (k % 4 != 0) ? es[k / 4] : 7'h7F;
            vectors++; if (cap_sg[k] !== eg) begin miscompares++; $display("FAIL lz_seg[%0d] got %h want %h", k, cap_sg[k], eg); end
        end
        vectors++; if (cap_an[13] !== 4'b0111) begin miscompares++; $display("FAIL lz_scan3 got %b want 0111", cap_an[13]); end
    endtask

    task automatic test_lz_dp();
        logic [6:0] es [4];
        logic       ed [4];
        logic [6:0] eg;
        es = '{~7'h3F, 7'h7F, ~7'h3F, 7'h7F};
        ed = '{1'b1, 1'b1, 1'b0, 1'b1};
        do_load(16'h0000, 4'b0100, 1'b1);
        capture_frame();
        vectors++; if (cap_to) begin miscompares++; $display("FAIL lzdp_timeout got none want frame_start"); end
        for (int k = 0; k < 16; k++) begin
            if (k / 4 != 1) begin
                eg = (k % 4 != 0) ? es[k / 4] : 7'h7F;
                vectors++; if (cap_sg[k] !== eg) begin miscompares++; $display("FAIL lzdp_seg[%0d] got %h want %h", k, cap_sg[k], eg); end
            end
            vectors++;
            if (cap_dp[k] !== ((k % 4 != 0) ? ed[k / 4] : 1'b1)) begin
                miscompares++; $display("FAIL lzdp_dp[%0d] got %b want %b", k, cap_dp[k], (k % 4 != 0) ? ed[k / 4] : 1'b1);
            end
        end
    endtask

    task automatic test_last_load();
        do_load(16'hAAAA, 4'b0000, 1'b0);
        do_load(16'h5555, 4'b0000, 1'b0);
        vectors++; if (anode !== 4'b1011) begin miscompares++; $display("FAIL ll_cur_anode got %b want 1011", anode); end
        vectors++; if (segment !== ~7'h3F) begin miscompares++; $display("FAIL ll_cur_seg got %h want %h", segment, ~7'h3F); end
        vectors++; if (dp !== 1'b0) begin miscompares++; $display("FAIL ll_cur_dp got %b want 0", dp); end
        capture_frame();
        vectors++; if (cap_to) begin miscompares++; $display("FAIL ll_timeout got none want frame_start"); end
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (cap_sg[k] !== ((k % 4 != 0) ? ~7'h6D : 7'h7F)) begin
                miscompares++; $display("FAIL ll_seg[%0d] got %h want %h", k, cap_sg[k], (k % 4 != 0) ? ~7'h6D : 7'h7F);
            end
        end
    endtask

    task automatic test_boundary_load();
        repeat (15) @(negedge clk);
        hex_in = 16'h8888; dp_in = 4'b0000; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        capture_frame();
        vectors++; if (cap_to) begin miscompares++; $display("FAIL bnd_timeout1 got none want frame_start"); end
        for (int k = 1; k < 16; k += 4) begin
            vectors++; if (cap_sg[k] !== ~7'h6D) begin miscompares++; $display("FAIL bnd_old[%0d] got %h want %h", k, cap_sg[k], ~7'h6D); end
        end
        capture_frame();
        vectors++; if (cap_to) begin miscompares++; $display("FAIL bnd_timeout2 got none want frame_start"); end
        for (int k = 1; k < 16; k += 4) begin
            vectors++; if (cap_sg[k] !== ~7'h7F) begin miscompares++; $display("FAIL bnd_new[%0d] got %h want %h", k, cap_sg[k], ~7'h7F); end
        end
    endtask

    task automatic test_reset_mid();
        repeat (10) @(negedge clk);
        vectors++; if (anode !== 4'b1011) begin miscompares++; $display("FAIL rm_slot2 got %b want 1011", anode); end
        vectors++; if (segment !== ~7'h7F) begin miscompares++; $display("FAIL rm_seg2 got %h want %h", segment, ~7'h7F); end
        rst = 1'b1;
        #1;
        vectors++; if (anode !== 4'hF) begin miscompares++; $display("FAIL rm_async_anode got %b want 1111", anode); end
        vectors++; if (segment !== 7'h7F) begin miscompares++; $display("FAIL rm_async_seg got %h want 7f", segment); end
        vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL rm_async_fs got %b want 0", frame_start); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL rm_fs got %b want 1", frame_start); end
        vectors++; if (anode !== 4'hF) begin miscompares++; $display("FAIL rm_dead got %b want 1111", anode); end
        @(negedge clk);
        vectors++; if (anode !== 4'b1110) begin miscompares++; $display("FAIL rm_anode got %b want 1110", anode); end
        vectors++; if (segment !== ~7'h3F) begin miscompares++; $display("FAIL rm_seg got %h want %h", segment, ~7'h3F); end
    endtask

    task automatic test_frame_period();
        int last;
        int pulses;
        last = 0;
        pulses = 0;
        for (int c = 2; c <= 50; c++) begin
            @(negedge clk);
            vectors++;
            if ($countones(~anode) > 1) begin miscompares++; $display("FAIL fp_onehot[%0d] got %b want <=1 low", c, anode); end
            if (frame_start === 1'b1) begin
                vectors++;
                if (c - last != 16) begin miscompares++; $display("FAIL fp_period got %0d want 16", c - last); end
                last = c;
                pulses++;
            end
        end
        vectors++; if (pulses != 3) begin miscompares++; $display("FAIL fp_count got %0d want 3", pulses); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_lz();
        test_lz_dp();
        test_last_load();
        test_boundary_load();
        test_reset_mid();
        test_frame_period();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m_7seg_scan_driver.md
M_7SEG_SCAN_DRIVER -- requirements
Module: m_7seg_scan_driver

Interface
Parameters:
REQ-001 SHALL have parameter NUM_DIGITS, default 4; number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000; clock cycles per digit slot, minimum 4.
REQ-003 SHALL have parameter DEAD_CYC, default 2; blanking cycles at the start of each slot, legal range 1..SCAN_DIV-2.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; when 1, segment, dp and anode outputs are all active-low.

Ports:
REQ-005 SHALL provide port clk, input, 1 bit; the single clock. All logic SHALL be clocked on its rising edge.
REQ-006 SHALL provide port rst, input, 1 bit; asynchronous, active-high reset.
REQ-007 SHALL provide port hex_in, input, 4*NUM_DIGITS bits; nibble i is the value shown on digit i, with digit 0 the least significant.
REQ-008 SHALL provide port dp_in, input, NUM_DIGITS bits; decimal-point request for each digit.
REQ-009 SHALL provide port load, input, 1 bit; a one-cycle strobe that captures hex_in, dp_in and blank_lz into the pending register.
REQ-010 SHALL provide port blank_lz, input, 1 bit; enables leading-zero blanking.
REQ-011 SHALL provide port segment, output, 7 bits; segment drive ordered {g,f,e,d,c,b,a}.
REQ-012 SHALL provide port dp, output, 1 bit; decimal-point drive.
REQ-013 SHALL provide port anode, output, NUM_DIGITS bits; one-hot digit select.
REQ-014 SHALL provide port frame_start, output, 1 bit; a one-cycle pulse when digit 0's slot begins.

Function
REQ-015 SHALL use a prescaler that counts 0..SCAN_DIV-1 and wraps. At wrap, digit index idx SHALL advance by one, wrapping from NUM_DIGITS-1 to 0.
REQ-016 SHALL hold all anodes inactive while the prescaler is below DEAD_CYC, and assert only anode[idx] for the rest of the slot.
REQ-017 SHALL drive segment and dp inactive (all off) whenever no anode is asserted.
REQ-018 SHALL copy the pending register into the display register in the same cycle that idx wraps to 0. frame_start SHALL pulse in that cycle.
REQ-019 SHALL let a later load overwrite an earlier one before the frame boundary (last load wins). A load coinciding with the frame boundary SHALL be applied at the next boundary, never mid-frame.
REQ-020 SHALL decode glyphs in active-high {g..a} form as follows: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. When ACTIVE_LOW=1, segment, dp and anode SHALL all be inverted.
REQ-021 SHALL, when displayed blank_lz=1, blank every digit i>0 whose nibble and all higher nibbles are 0 and whose dp bit is 0 (segments off, anode still scanned). Digit 0 SHALL never be blanked.
REQ-022 SHALL register all outputs (no combinational path from inputs to outputs). Latency from slot start to a valid anode is DEAD_CYC cycles.

Reset
REQ-023 SHALL, on rst, asynchronously clear the prescaler, idx, pending register and display register, and clear blank_lz to 0.
REQ-024 SHALL, during reset, drive all outputs inactive and frame_start=0. The first slot after reset release SHALL be digit 0 with a fresh dead time, and frame_start SHALL pulse in the first cycle after reset release.
REQ-025 SHALL, on reset mid-slot, drop anodes to inactive in the same cycle without waiting for a clock edge.

Structure
REQ-026 SHALL place the glyph table (16 x 7-bit localparam array) and the segment-order constants in the shared package seg7_pkg.
REQ-027 SHALL implement the nibble-to-glyph lookup in one sub-module, seg7_glyph (combinational). The prescaler, scan logic and registers SHALL stay in the top module.

Verification
(All scenarios use NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYC=1, ACTIVE_LOW=1.)
REQ-028 Reset then load hex_in=16'h1234, dp_in=0 -> after the next frame_start, slot 0 shows anode=4'b1110 and segment=~7'h66 for 3 cycles, and slot 1 shows ~7'h4F. Each slot is preceded by 1 cycle with anode=4'hF.
REQ-029 Load 16'h0042 with blank_lz=1 -> digits 3 and 2 show segment=7'h7F, and digits 1 and 0 show ~7'h66 and ~7'h5B.
REQ-030 Load 16'h0000 with blank_lz=1 and dp_in=4'b0100 -> digit 2 shows ~7'h3F with dp=0, digit 3 is blanked, and digit 0 shows ~7'h3F.
REQ-031 Load 16'hAAAA mid-frame, then load 16'h5555 before the boundary -> the current frame is unchanged and the next frame shows ~7'h6D on all digits.
REQ-032 Assert rst during slot 2 for 1 cycle -> anode=4'hF immediately, and after release frame_start=1, followed 1 cycle later by anode=4'b1110.
REQ-033 Run 3 full frames -> frame_start pulses exactly every 16 cycles, and anode is never more than one-hot.
